// File: rtl/axi_stream_pkg.sv
// Shared definitions for the stream generator/sink pair: register map,
// control/status bit positions and the sink checker state encoding.
package axi_stream_pkg;

  localparam logic [31:0] REG_CONTROL      = 32'h00;
  localparam logic [31:0] REG_STATUS       = 32'h04;
  localparam logic [31:0] REG_PKT_COUNT    = 32'h08;
  localparam logic [31:0] REG_BEAT_COUNT   = 32'h0C;
  localparam logic [31:0] REG_LAST_LEN     = 32'h10;
  localparam logic [31:0] REG_LAST_ID_DEST = 32'h14;
  localparam logic [31:0] REG_ERR_COUNT    = 32'h18;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_CLEAR    = 1;
  localparam int CTRL_THROTTLE = 2;

  localparam int STAT_IN_PKT = 0;
  localparam int STAT_ERROR  = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } sink_state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axi_lite_regs_slave.sv
// AXI4-Lite slave handshake plus a register file with one writable CONTROL
// register; all other mapped registers are read-only views of the inputs.
module axi_lite_regs_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [DATA_W-1:0] ctrl_o,
  output logic              clear_o,
  input  logic [DATA_W-1:0] status_i,
  input  logic [DATA_W-1:0] pkt_count_i,
  input  logic [DATA_W-1:0] beat_count_i,
  input  logic [DATA_W-1:0] last_len_i,
  input  logic [DATA_W-1:0] last_id_dest_i,
  input  logic [DATA_W-1:0] err_count_i
);
  import axi_stream_pkg::*;

  localparam logic [DATA_W-1:0] CLEAR_MASK = ~(DATA_W'(1) << CTRL_CLEAR);

  logic              awready_q, awready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              bvalid_q, bvalid_d;
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              aw_hs, ar_hs, wr_ctrl;
  logic [DATA_W-1:0] rd_mux;

  function automatic logic [31:0] word_addr(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = '0;
    w[ADDR_W-1:0] = a;
    w[1:0] = 2'b00;
    return w;
  endfunction

  always_comb begin
    aw_hs     = awready_q & awvalid_i & wvalid_i;
    awready_d = awvalid_i & wvalid_i & ~awready_q & ~wr_en_q & ~bvalid_q;
    wr_en_d   = aw_hs;
    wr_ctrl   = wr_en_q && (word_addr(waddr_q) == REG_CONTROL);
    ctrl_d    = wr_ctrl ? (wdata_q & CLEAR_MASK) : ctrl_q;
    bvalid_d  = wr_en_q ? 1'b1 : (bready_i ? 1'b0 : bvalid_q);

    ar_hs     = arready_q & arvalid_i;
    arready_d = arvalid_i & ~arready_q & ~rvalid_q;
    rvalid_d  = ar_hs ? 1'b1 : (rready_i ? 1'b0 : rvalid_q);
    rdata_d   = ar_hs ? rd_mux : rdata_q;
  end

  always_comb begin
    rd_mux = '0;
    case (word_addr(araddr_i))
      REG_CONTROL:      rd_mux = ctrl_q;
      REG_STATUS:       rd_mux = status_i;
      REG_PKT_COUNT:    rd_mux = pkt_count_i;
      REG_BEAT_COUNT:   rd_mux = beat_count_i;
      REG_LAST_LEN:     rd_mux = last_len_i;
      REG_LAST_ID_DEST: rd_mux = last_id_dest_i;
      REG_ERR_COUNT:    rd_mux = err_count_i;
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      awready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      ctrl_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= awready_d;
      wr_en_q   <= wr_en_d;
      if (aw_hs) begin
        waddr_q <= awaddr_i;
        wdata_q <= wdata_i;
      end
      bvalid_q  <= bvalid_d;
      ctrl_q    <= ctrl_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  // Clear is live only in the cycle the CONTROL write lands; it is never stored.
  assign clear_o   = wr_ctrl & wdata_q[CTRL_CLEAR];
  assign ctrl_o    = ctrl_q;
  assign awready_o = awready_q;
  assign wready_o  = awready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = 2'b00;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = 2'b00;

endmodule

// File: rtl/axi_stream_sink.sv
// AXI4-Stream traffic checker: verifies the incrementing per-packet pattern
// and keeps packet/beat/error statistics readable over AXI4-Lite.
module axi_stream_sink #(
  parameter int STREAM_DATA_WIDTH  = 32,
  parameter int STREAM_ID_WIDTH    = 2,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic [STREAM_DATA_WIDTH-1:0]    TDATA,
  input  logic                            TLAST,
  input  logic [STREAM_ID_WIDTH-1:0]      TID,
  input  logic [1:0]                      TDEST,
  input  logic                            TVALID,
  output logic                            TREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  import axi_stream_pkg::*;

  // state     | meaning
  // ST_IDLE   | between packets, next beat is beat 0
  // ST_IN_PKT | first beat taken, waiting for TLAST

  localparam int BYTES_PER_BEAT = STREAM_DATA_WIDTH / 8;

  sink_state_e                   state_q, state_d;
  logic [23:0]                   beat_idx_q, beat_idx_d;
  logic [STREAM_ID_WIDTH-1:0]    first_id_q;
  logic [1:0]                    first_dest_q;
  logic                          tready_q, toggle_q;
  logic [31:0]                   pkt_count_q, beat_count_q, err_count_q;
  logic [31:0]                   last_len_q, last_id_dest_q;
  logic                          error_q;

  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl, status;
  logic                          clear, enable, throttle;
  logic                          fire, in_pkt, beat_err;
  logic [STREAM_DATA_WIDTH-1:0]  expected;
  logic [STREAM_ID_WIDTH-1:0]    pkt_id;
  logic [1:0]                    pkt_dest;
  logic                          unused_ok;

  assign enable   = ctrl[CTRL_ENABLE];
  assign throttle = ctrl[CTRL_THROTTLE];
  assign fire     = TVALID & tready_q;
  assign TREADY   = tready_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fire && !TLAST) state_d = ST_IN_PKT;
      ST_IN_PKT: if (fire && TLAST)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_pkt     = (state_q == ST_IN_PKT);
    expected   = STREAM_DATA_WIDTH'(beat_idx_q);
    pkt_id     = in_pkt ? first_id_q : TID;
    pkt_dest   = in_pkt ? first_dest_q : TDEST;
    beat_err   = fire && ((TDATA != expected) ||
                          (in_pkt && ((TID != first_id_q) || (TDEST != first_dest_q))));
    beat_idx_d = beat_idx_q;
    if (fire) beat_idx_d = TLAST ? 24'd0 : beat_idx_q + 24'd1;
  end

  // Throttle: the toggle flips every cycle, gating TREADY to every other cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      toggle_q <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      toggle_q <= throttle ? ~toggle_q : 1'b0;
      tready_q <= enable & (~throttle | toggle_q);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      beat_idx_q     <= '0;
      first_id_q     <= '0;
      first_dest_q   <= '0;
      pkt_count_q    <= '0;
      beat_count_q   <= '0;
      err_count_q    <= '0;
      last_len_q     <= '0;
      last_id_dest_q <= '0;
      error_q        <= 1'b0;
    end else begin
      beat_idx_q <= beat_idx_d;
      if (fire && !in_pkt) begin
        first_id_q   <= TID;
        first_dest_q <= TDEST;
      end
      if (fire && TLAST) begin
        last_len_q     <= (32'(beat_idx_q) + 32'd1) * 32'(BYTES_PER_BEAT);
        last_id_dest_q <= 32'({pkt_id, 6'b000000, pkt_dest});
      end
      // A clear landing on a fire cycle drops that beat's statistics.
      if (clear) begin
        pkt_count_q  <= '0;
        beat_count_q <= '0;
        err_count_q  <= '0;
        error_q      <= 1'b0;
      end else begin
        if (fire)          beat_count_q <= sat_inc(beat_count_q);
        if (fire && TLAST) pkt_count_q  <= sat_inc(pkt_count_q);
        if (beat_err) begin
          err_count_q <= sat_inc(err_count_q);
          error_q     <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    status              = '0;
    status[STAT_IN_PKT] = in_pkt;
    status[STAT_ERROR]  = error_q;
  end

  axi_lite_regs_slave #(
    .DATA_W (C_S_AXI_DATA_WIDTH),
    .ADDR_W (C_S_AXI_ADDR_WIDTH)
  ) u_regs (
    .clock          (clock),
    .resetn         (resetn),
    .awaddr_i       (S_AXI_AWADDR),
    .awvalid_i      (S_AXI_AWVALID),
    .awready_o      (S_AXI_AWREADY),
    .wdata_i        (S_AXI_WDATA),
    .wvalid_i       (S_AXI_WVALID),
    .wready_o       (S_AXI_WREADY),
    .bresp_o        (S_AXI_BRESP),
    .bvalid_o       (S_AXI_BVALID),
    .bready_i       (S_AXI_BREADY),
    .araddr_i       (S_AXI_ARADDR),
    .arvalid_i      (S_AXI_ARVALID),
    .arready_o      (S_AXI_ARREADY),
    .rdata_o        (S_AXI_RDATA),
    .rresp_o        (S_AXI_RRESP),
    .rvalid_o       (S_AXI_RVALID),
    .rready_i       (S_AXI_RREADY),
    .ctrl_o         (ctrl),
    .clear_o        (clear),
    .status_i       (status),
    .pkt_count_i    (C_S_AXI_DATA_WIDTH'(pkt_count_q)),
    .beat_count_i   (C_S_AXI_DATA_WIDTH'(beat_count_q)),
    .last_len_i     (C_S_AXI_DATA_WIDTH'(last_len_q)),
    .last_id_dest_i (C_S_AXI_DATA_WIDTH'(last_id_dest_q)),
    .err_count_i    (C_S_AXI_DATA_WIDTH'(err_count_q))
  );

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, ctrl};

endmodule

// File: tb/tb_axi_stream_sink.sv
// Randomized bench for axi_stream_sink with a packet-level reference model.
module tb_axi_stream_sink;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] TDATA = '0;
  logic        TLAST = 1'b0;
  logic [1:0]  TID = '0;
  logic [1:0]  TDEST = '0;
  logic        TVALID = 1'b0;
  logic        TREADY;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = 4'hF;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;

  always #5 clock = ~clock;

  axi_stream_sink #(
    .STREAM_DATA_WIDTH(32), .STREAM_ID_WIDTH(2),
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .clock(clock), .resetn(resetn),
    .TDATA(TDATA), .TLAST(TLAST), .TID(TID), .TDEST(TDEST),
    .TVALID(TVALID), .TREADY(TREADY),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
    logic [1:0]  dest;
  } beat_t;

  beat_t       cur_pkt[$];
  logic [31:0] m_pkt = '0, m_beat = '0, m_err = '0, m_len = '0, m_iddest = '0;
  logic        m_error = 1'b0, m_en = 1'b0, m_thr = 1'b0;
  logic        chk_tready = 1'b0;
  logic        prev_tready = 1'b0;
  int          cyc = 0, fire_cnt = 0, first_fire_cyc = 0, last_fire_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    cur_pkt.delete();
    m_pkt = '0; m_beat = '0; m_err = '0; m_len = '0; m_iddest = '0;
    m_error = 1'b0; m_en = 1'b0; m_thr = 1'b0;
  endfunction

  // Packet-level view: beat n of a packet must carry n and match beat 0's id/dest.
  function automatic void model_fire(input beat_t b, input logic last);
    logic bad;
    bad = (b.data != 32'(cur_pkt.size()));
    if (cur_pkt.size() > 0 && (b.id != cur_pkt[0].id || b.dest != cur_pkt[0].dest)) bad = 1'b1;
    cur_pkt.push_back(b);
    m_beat++;
    if (bad) begin
      m_err++;
      m_error = 1'b1;
    end
    if (last) begin
      m_pkt++;
      m_len    = 32'(cur_pkt.size() * 4);
      m_iddest = {22'b0, cur_pkt[0].id, 6'b0, cur_pkt[0].dest};
      cur_pkt.delete();
    end
  endfunction

  function automatic logic [31:0] m_status();
    return {30'b0, m_error, (cur_pkt.size() > 0)};
  endfunction

  always @(negedge clock) begin
    beat_t b;
    cyc++;
    if (!resetn) begin
      check("tready_in_reset", 32'(TREADY), 32'd0);
    end else begin
      if (chk_tready) begin
        if (!m_en)       check("tready_disabled", 32'(TREADY), 32'd0);
        else if (!m_thr) check("tready_enabled", 32'(TREADY), 32'd1);
        else             check("tready_alternates", 32'(TREADY), 32'(!prev_tready));
      end
      if (TVALID && TREADY) begin
        b.data = TDATA; b.id = TID; b.dest = TDEST;
        model_fire(b, TLAST);
        if (fire_cnt == 0) first_fire_cyc = cyc;
        fire_cnt++;
        last_fire_cyc = cyc;
      end
    end
    prev_tready = TREADY;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data);
    int n;
    chk_tready = 1'b0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50);
    check("aw_w_handshake", 32'(S_AXI_AWREADY && S_AXI_WREADY), 32'd1);
    @(posedge clock); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!S_AXI_BVALID && n < 50);
    check("bvalid_latency", 32'(n), 32'd2);
    check("bresp_okay", 32'(S_AXI_BRESP), 32'd0);
    @(posedge clock); #1;
    S_AXI_BREADY = 1'b0;
    if (addr == 5'h00) begin
      m_en  = data[0];
      m_thr = data[2];
      if (data[1]) begin
        m_pkt = '0; m_beat = '0; m_err = '0; m_error = 1'b0;
      end
    end
    tick(3);
    chk_tready = 1'b1;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    int n;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!S_AXI_ARREADY && n < 50);
    check("arready_seen", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge clock); #1;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!S_AXI_RVALID && n < 50);
    check("rvalid_latency", 32'(n), 32'd1);
    check("rresp_okay", 32'(S_AXI_RRESP), 32'd0);
    data = S_AXI_RDATA;
    @(posedge clock); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(name, d, exp);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] id,
                           input logic [1:0] dest);
    int n;
    TDATA = d; TLAST = last; TID = id; TDEST = dest; TVALID = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!TREADY && n < 100);
    check("beat_accepted", 32'(TREADY), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic idle();
    TVALID = 1'b0; TLAST = 1'b0;
  endtask

  task automatic send_seq(input int first, input int count, input int total,
                          input logic [1:0] id, input logic [1:0] dest);
    for (int i = first; i < first + count; i++)
      send_beat(32'(i), (i == total - 1), id, dest);
    idle();
  endtask

  task automatic chk_stats(input string tag);
    chk_reg({tag, "_pkt"}, 5'h08, m_pkt);
    chk_reg({tag, "_beat"}, 5'h0C, m_beat);
    chk_reg({tag, "_err"}, 5'h18, m_err);
    chk_reg({tag, "_status"}, 5'h04, m_status());
    chk_reg({tag, "_len"}, 5'h10, m_len);
    chk_reg({tag, "_iddest"}, 5'h14, m_iddest);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int len, bad_beat, kind;
    logic [1:0] id, dest;

    #1 resetn = 1'b0;
    #1;
    check("rst_tready", 32'(TREADY), 32'd0);
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    model_reset();
    tick(3);
    resetn = 1'b1;
    chk_tready = 1'b1;
    tick(1);
    chk_reg("rst_control", 5'h00, 32'h0);
    chk_reg("rst_status", 5'h04, 32'h0);
    chk_reg("rst_pkt", 5'h08, 32'h0);
    chk_reg("rst_err", 5'h18, 32'h0);

    // Register file behaviour
    axi_write(5'h00, 32'hA5A5_A501);
    chk_reg("ctrl_readback", 5'h00, 32'hA5A5_A501);
    axi_write(5'h08, 32'h0000_FFFF);
    chk_reg("ro_write_ignored", 5'h08, 32'h0);
    chk_reg("unmapped_read", 5'h1C, 32'h0);
    axi_write(5'h00, 32'h1);

    // 4-beat clean packet
    send_seq(0, 4, 4, 2'd1, 2'd2);
    chk_reg("p4_pkt", 5'h08, 32'd1);
    chk_reg("p4_beat", 5'h0C, 32'd4);
    chk_reg("p4_len", 5'h10, 32'd16);
    chk_reg("p4_iddest", 5'h14, 32'h102);
    chk_reg("p4_err", 5'h18, 32'd0);

    // Corrupted packet 0,5,2 then clear
    send_beat(32'd0, 1'b0, 2'd0, 2'd0);
    send_beat(32'd5, 1'b0, 2'd0, 2'd0);
    send_beat(32'd2, 1'b1, 2'd0, 2'd0);
    idle();
    chk_reg("bad_err", 5'h18, 32'd1);
    chk_reg("bad_status", 5'h04, 32'h2);
    axi_write(5'h00, 32'h3);
    chk_reg("clr_ctrl_reads_enable", 5'h00, 32'h1);
    chk_reg("clr_pkt", 5'h08, 32'd0);
    chk_reg("clr_beat", 5'h0C, 32'd0);
    chk_reg("clr_err", 5'h18, 32'd0);
    chk_reg("clr_status", 5'h04, 32'h0);

    // Throttled: 8 beats with TVALID held high
    axi_write(5'h00, 32'h5);
    fire_cnt = 0;
    send_seq(0, 8, 8, 2'd0, 2'd1);
    check("thr_beats", 32'(fire_cnt), 32'd8);
    check("thr_span", 32'(last_fire_cyc - first_fire_cyc), 32'd14);
    chk_reg("thr_err", 5'h18, 32'd0);
    chk_reg("thr_pkt", 5'h08, 32'd1);

    // Single-beat packet
    axi_write(5'h00, 32'h3);
    send_seq(0, 1, 1, 2'd2, 2'd3);
    chk_reg("one_pkt", 5'h08, 32'd1);
    chk_reg("one_len", 5'h10, 32'd4);
    chk_reg("one_status", 5'h04, 32'h0);
    chk_reg("one_iddest", 5'h14, 32'h203);

    // Pause mid-packet by disabling
    axi_write(5'h00, 32'h3);
    send_seq(0, 2, 6, 2'd1, 2'd1);
    axi_write(5'h00, 32'h0);
    tick(10);
    chk_reg("pause_status", 5'h04, 32'h1);
    axi_write(5'h00, 32'h1);
    send_seq(2, 4, 6, 2'd1, 2'd1);
    chk_reg("resume_pkt", 5'h08, 32'd1);
    chk_reg("resume_err", 5'h18, 32'd0);
    chk_reg("resume_len", 5'h10, 32'd24);

    // Reset mid-packet
    send_seq(0, 2, 4, 2'd3, 2'd0);
    chk_tready = 1'b0;
    #3 resetn = 1'b0;
    #1;
    check("midrst_tready", 32'(TREADY), 32'd0);
    model_reset();
    tick(2);
    #2 resetn = 1'b1;
    chk_tready = 1'b1;
    tick(1);
    chk_reg("midrst_pkt", 5'h08, 32'd0);
    chk_reg("midrst_beat", 5'h0C, 32'd0);
    chk_reg("midrst_status", 5'h04, 32'h0);
    axi_write(5'h00, 32'h1);
    send_seq(0, 4, 4, 2'd3, 2'd1);
    chk_reg("after_rst_pkt", 5'h08, 32'd1);
    chk_reg("after_rst_err", 5'h18, 32'd0);
    chk_reg("after_rst_iddest", 5'h14, 32'h301);

    // Randomized traffic against the model
    for (int p = 0; p < 40; p++) begin
      axi_write(5'h00, {29'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'b1});
      len  = $urandom_range(1, 6);
      id   = 2'($urandom_range(0, 3));
      dest = 2'($urandom_range(0, 3));
      bad_beat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      kind = $urandom_range(0, 1);
      for (int i = 0; i < len; i++) begin
        d = 32'(i);
        if (i == bad_beat) begin
          if (kind == 1 && i > 0) send_beat(d, (i == len - 1), id ^ 2'd1, dest);
          else                    send_beat(d ^ 32'h100, (i == len - 1), id, dest);
        end else begin
          send_beat(d, (i == len - 1), id, dest);
        end
        if ($urandom_range(0, 2) == 0) begin
          idle();
          tick($urandom_range(1, 2));
        end
      end
      idle();
      if (p % 4 == 3) chk_stats("rnd");
    end
    chk_stats("rnd_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
